gmii_tx_ctrl: RTL and testbench

//  Transmit frame sequencer between the encapsulation byte stream and the GMII pins.

---
 rtl/eth_pkg.sv | 34 +++
 rtl/crc32_d8.sv | 22 ++
 rtl/gmii_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gmii_tx_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet TX constants, state type and CRC-32 byte step
// GMII_TX_FCS_EN adds the FCS state to tx_state_t.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam int          len_max_payload = 1514;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_PAYLOAD,
      ST_PAD,
`ifdef GMII_TX_FCS_EN
      ST_FCS,
`endif
      ST_DROP,
      ST_IFG
   } tx_state_t;

   // Reflected CRC-32, one byte per call, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational CRC-32 step, 8 bits per cycle
// Used by gmii_tx_ctrl only when GMII_TX_FCS_EN is defined.
module crc32_d8
   import eth_pkg::*;
(
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   input  logic [31:0] crc_i,
   output logic [31:0] crc_o
);

   always_comb begin
      crc_o = crc_i;
      if (clr_i) begin
         crc_o = CRC32_INIT;
      end else if (en_i) begin
         crc_o = crc32_byte(crc_i, data_i);
      end
   end

endmodule

// File: rtl/gmii_tx_ctrl.sv
// rtl/gmii_tx_ctrl.sv - GMII transmit frame sequencer (preamble, SFD, payload, pad, FCS, IFG)
// Define GMII_TX_FCS_EN to append a CRC-32 FCS; otherwise the upstream block supplies it.
module gmii_tx_ctrl
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int MAX_FRAME    = len_max_payload,
   parameter int IFG_BYTES    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy,
   output logic       underrun
);

   localparam logic [13:0] MIN_CNT  = 14'(MIN_FRAME);
   localparam logic [13:0] MAX_CNT  = 14'(MAX_FRAME);
   localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
   localparam logic [3:0]  IFG_LAST = 4'(IFG_BYTES - 1);

`ifdef GMII_TX_FCS_EN
   localparam tx_state_t ST_END = ST_FCS;
`else
   localparam tx_state_t ST_END = ST_IFG;
`endif

   tx_state_t   state_q;
   logic [3:0]  cnt_q;
   logic [13:0] byte_cnt_q;
   logic [13:0] byte_cnt_d;
   logic [7:0]  txd_q;
   logic        tx_en_q;
   logic        tx_er_q;
   logic        underrun_q;

   assign byte_cnt_d = (byte_cnt_q == 14'h3FFF) ? byte_cnt_q : byte_cnt_q + 14'd1;

`ifdef GMII_TX_FCS_EN
   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic [31:0] fcs_w;
   logic        crc_en;

   assign crc_en = ((state_q == ST_PAYLOAD) && s_valid && (byte_cnt_q != MAX_CNT))
                   || (state_q == ST_PAD);
   assign fcs_w  = ~crc_q;

   crc32_d8 u_crc (
      .clr_i  (state_q == ST_SFD),
      .en_i   (crc_en),
      .data_i ((state_q == ST_PAD) ? 8'h00 : s_data),
      .crc_i  (crc_q),
      .crc_o  (crc_d)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_q <= CRC32_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end
`endif

   // Outputs are registered one cycle behind the state that decides them;
   // IDLE already drives the first preamble byte so the IFG stays exactly IFG_BYTES.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         byte_cnt_q <= '0;
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         underrun_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_valid) begin
                  state_q <= ST_PREAMBLE;
                  txd_q   <= ETH_PREAMBLE;
                  tx_en_q <= 1'b1;
                  cnt_q   <= 4'd1;
               end
            end
            ST_PREAMBLE: begin
               txd_q   <= ETH_PREAMBLE;
               tx_en_q <= 1'b1;
               if (cnt_q >= PRE_LAST) begin
                  state_q <= ST_SFD;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_SFD: begin
               txd_q      <= ETH_SFD;
               tx_en_q    <= 1'b1;
               byte_cnt_q <= '0;
               state_q    <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               tx_en_q <= 1'b1;
               cnt_q   <= '0;
               if (!s_valid || (byte_cnt_q == MAX_CNT)) begin
                  tx_er_q    <= 1'b1;
                  underrun_q <= 1'b1;
                  state_q    <= (s_valid && s_last) ? ST_IFG : ST_DROP;
               end else begin
                  txd_q      <= s_data;
                  byte_cnt_q <= byte_cnt_d;
                  if (s_last) begin
                     state_q <= (byte_cnt_d < MIN_CNT) ? ST_PAD : ST_END;
                  end
               end
            end
            ST_PAD: begin
               tx_en_q    <= 1'b1;
               byte_cnt_q <= byte_cnt_d;
               cnt_q      <= '0;
               if (byte_cnt_d >= MIN_CNT) begin
                  state_q <= ST_END;
               end
            end
`ifdef GMII_TX_FCS_EN
            ST_FCS: begin
               txd_q   <= fcs_w[{cnt_q[1:0], 3'b000} +: 8];
               tx_en_q <= 1'b1;
               if (cnt_q[1:0] == 2'd3) begin
                  cnt_q   <= '0;
                  state_q <= ST_IFG;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
`endif
            ST_DROP: begin
               cnt_q <= '0;
               if (s_valid && s_last) begin
                  state_q <= ST_IFG;
               end
            end
            ST_IFG: begin
               if (cnt_q >= IFG_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_ready    = (state_q == ST_PAYLOAD) || (state_q == ST_DROP);
   assign busy       = (state_q != ST_IDLE);
   assign gmii_txd   = txd_q;
   assign gmii_tx_en = tx_en_q;
   assign gmii_tx_er = tx_er_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_gmii_tx_ctrl.sv
// tb/tb_gmii_tx_ctrl.sv - scoreboard bench for gmii_tx_ctrl
// Expected lengths follow GMII_TX_FCS_EN when the bench is built with it.
module tb_gmii_tx_ctrl;

   localparam int MIN_F = 60;
   localparam int MAX_F = 1514;
`ifdef GMII_TX_FCS_EN
   localparam int FCS_LEN = 4;
`else
   localparam int FCS_LEN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       busy;
   logic       underrun;

   always #4 clk = ~clk;

   gmii_tx_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .gmii_tx_er (gmii_tx_er),
      .busy       (busy),
      .underrun   (underrun)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         en_run = 0, last_run = 0, low_run = 0, last_gap = 0;
   int         er_cnt = 0, er_en_cnt = 0, ur_cnt = 0;
   logic [7:0] first_byte = 8'h00;
   logic       prev_en = 1'b0;
   logic [31:0] crc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Wire monitor: pops the scoreboard on every clean tx_en byte, tracks runs and gaps.
   always @(negedge clk) begin
      logic [31:0] expv;
      if (gmii_tx_en) begin
         en_run++;
         if (!prev_en) begin
            first_byte = gmii_txd;
            last_gap   = low_run;
            low_run    = 0;
         end
         if (gmii_tx_er) begin
            er_en_cnt++;
         end else begin
            expv = 32'h100;
            if (exp_q.size() > 0) expv = {24'h0, exp_q.pop_front()};
            check_eq("wire_byte", {24'h0, gmii_txd}, expv);
         end
      end else begin
         if (prev_en) begin
            last_run = en_run;
            en_run   = 0;
         end
         low_run++;
      end
      if (gmii_tx_er) er_cnt++;
      if (underrun) ur_cnt++;
      prev_en = gmii_tx_en;
   end

   task automatic push_byte(input logic [7:0] d, input logic last);
      int t;
      s_data = d; s_valid = 1'b1; s_last = last; t = 0;
      @(negedge clk);
      while (!s_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) check_eq("push_timeout", {31'h0, s_ready}, 32'h1);
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input int len, input int gap_at, input int rst_at, input int fixed);
      logic [7:0]  d;
      logic [31:0] f;
      bit          ab;
      int          n;
      ab = 1'b0; n = 0; crc = 32'hFFFFFFFF;
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < len; i++) begin
         if (i == rst_at) return;
         if (i == gap_at) begin
            s_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            ab = 1'b1;
         end
         if (i >= MAX_F) ab = 1'b1;
         d = (fixed >= 0) ? 8'(fixed) : 8'($urandom_range(0, 255));
         push_byte(d, i == len - 1);
         if (!ab) begin
            exp_q.push_back(d);
            crc = crc_step(crc, d);
            n++;
         end
      end
      if (!ab) begin
         for (int i = n; i < MIN_F; i++) begin
            exp_q.push_back(8'h00);
            crc = crc_step(crc, 8'h00);
         end
         f = ~crc;
         for (int k = 0; k < FCS_LEN; k++) exp_q.push_back(f[8*k +: 8]);
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (busy && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      if (busy) check_eq("idle_timeout", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      int c, u0, e0, x0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_txd", {24'h0, gmii_txd}, 32'h0);
      check_eq("rst_tx_en", {31'h0, gmii_tx_en}, 32'h0);
      check_eq("rst_tx_er", {31'h0, gmii_tx_er}, 32'h0);
      check_eq("rst_s_ready", {31'h0, s_ready}, 32'h0);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_underrun", {31'h0, underrun}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      // One-byte frame: full pad.
      e0 = er_cnt;
      send_frame(1, -1, -1, 8'hAB);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("f1_run", last_run, 68 + FCS_LEN);
      check_eq("f1_q_empty", exp_q.size(), 0);
      check_eq("f1_no_er", er_cnt - e0, 0);

      // 100-, 60- and 59-byte frames around the pad boundary.
      send_frame(100, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("f100_run", last_run, 108 + FCS_LEN);
      send_frame(60, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("f60_run", last_run, 68 + FCS_LEN);
      send_frame(59, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("f59_run", last_run, 68 + FCS_LEN);
      check_eq("f59_q_empty", exp_q.size(), 0);

      // Back-to-back frames with s_valid held high.
      send_frame(64, -1, -1, -1);
      send_frame(10, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("b2b_gap", last_gap, 12);
      check_eq("b2b_first", {24'h0, first_byte}, 32'h55);
      check_eq("b2b_run", last_run, 68 + FCS_LEN);
      check_eq("b2b_q_empty", exp_q.size(), 0);

      // Underrun after byte 20 of 40.
      u0 = ur_cnt; e0 = er_en_cnt; x0 = er_cnt;
      send_frame(40, 20, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("ur_ifg", c, 12);
      check_eq("ur_run", last_run, 29);
      check_eq("ur_pulse", ur_cnt - u0, 1);
      check_eq("ur_er_en", er_en_cnt - e0, 1);
      check_eq("ur_er_total", er_cnt - x0, 1);
      check_eq("ur_q_empty", exp_q.size(), 0);

      // Largest legal frame, then one byte over.
      u0 = ur_cnt;
      send_frame(MAX_F, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("max_run", last_run, 1522 + FCS_LEN);
      check_eq("max_no_ur", ur_cnt - u0, 0);
      send_frame(MAX_F + 1, -1, -1, -1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("ovs_ifg", c, 12);
      check_eq("ovs_run", last_run, 1523);
      check_eq("ovs_pulse", ur_cnt - u0, 1);
      check_eq("ovs_q_empty", exp_q.size(), 0);

      // Reset during payload byte 30.
      u0 = ur_cnt;
      send_frame(50, -1, 30, -1);
      rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mrst_tx_en", {31'h0, gmii_tx_en}, 32'h0);
      check_eq("mrst_txd", {24'h0, gmii_txd}, 32'h0);
      check_eq("mrst_s_ready", {31'h0, s_ready}, 32'h0);
      check_eq("mrst_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(negedge clk);
      check_eq("mrst_run", last_run, 38);
      check_eq("mrst_q_empty", exp_q.size(), 0);
      check_eq("mrst_no_ur", ur_cnt - u0, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send_frame(1, -1, -1, 8'h3C);
      s_valid = 1'b0; s_last = 1'b0;
      wait_idle(c);
      check_eq("post_rst_run", last_run, 68 + FCS_LEN);
      check_eq("post_rst_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1);
   end

endmodule
